// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package if_pkg;

    localparam int XLEN_DEF = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
        logic                misalign;
    } if_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous in-order FIFO; clear drops all entries and wins over push/pop.
module if_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i && !reset) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: one outstanding imem read, results queued in order for decode.
// IF_FETCH_ALIGN_CHK_EN: misaligned PCs become marker entries instead of reads.
//
// state | meaning
// IDLE  | may request a read for pc_in when the queue has room
// WAIT  | read granted, waiting for its response
// DROP  | flushed while waiting; response will be discarded
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = XLEN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_adv,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic            dec_misalign
);
`ifdef IF_FETCH_ALIGN_CHK_EN
    localparam int MB = 1;
`else
    localparam int MB = 0;
`endif
    localparam int EW = 2*XLEN + MB;

    fetch_state_e          state_q;
    logic [XLEN-1:0]       pend_pc_q;
    logic [EW-1:0]         last_q;
    logic [EW-1:0]         head, sel, wdata;
    logic [$clog2(DEPTH):0] count;
    logic                  full, empty;
    logic                  misalign, idle_ok, rsp_push, mis_push, push;

`ifdef IF_FETCH_ALIGN_CHK_EN
    assign misalign = (pc_in[1:0] != 2'b00);
    assign wdata    = rsp_push ? {pend_pc_q, imem_rdata, 1'b0}
                               : {pc_in, XLEN'(INSTR_NOP), 1'b1};
    assign dec_misalign = sel[0];
`else
    assign misalign = 1'b0;
    assign wdata    = {pend_pc_q, imem_rdata};
    assign dec_misalign = 1'b0;
`endif

    assign idle_ok   = (state_q == IDLE) && !reset && !flush && !full;
    assign imem_req  = idle_ok && !misalign;
    assign imem_addr = {pc_in[XLEN-1:2], 2'b00};
    assign rsp_push  = (state_q == WAIT) && imem_rvalid && !flush;
    assign mis_push  = idle_ok && misalign;
    assign push      = rsp_push || mis_push;
    assign pc_adv    = (imem_req && imem_gnt) || mis_push;

    // Empty queue presents the last head seen rather than stale storage.
    assign dec_valid = (count != '0);
    assign sel       = dec_valid ? head : last_q;
    assign dec_pc    = sel[EW-1 -: XLEN];
    assign dec_instr = sel[MB +: XLEN];

    if_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (dec_valid && dec_ready),
        .clear_i (flush),
        .wdata_i (wdata),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pend_pc_q <= '0;
            last_q    <= '0;
        end else begin
            if (!empty) last_q <= head;
            case (state_q)
                IDLE: if (imem_req && imem_gnt) begin
                    pend_pc_q <= pc_in;
                    state_q   <= WAIT;
                end
                WAIT: if (imem_rvalid)  state_q <= IDLE;
                      else if (flush)   state_q <= DROP;
                DROP: if (imem_rvalid)  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomised bench for if_fetch_queue against a queue-based reference model.
module tb_if_fetch_queue;
    import if_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [XLEN-1:0] pc_in = '0;
    logic            pc_adv;
    logic            flush = 1'b0;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt = 1'b0;
    logic            imem_rvalid = 1'b0;
    logic [XLEN-1:0] imem_rdata = '0;
    logic            dec_valid;
    logic            dec_ready = 1'b0;
    logic [XLEN-1:0] dec_instr;
    logic [XLEN-1:0] dec_pc;
    logic            dec_misalign;

    always #5 clk = ~clk;

    if_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_in        (pc_in),
        .pc_adv       (pc_adv),
        .flush        (flush),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_instr    (dec_instr),
        .dec_pc       (dec_pc),
        .dec_misalign (dec_misalign)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: queue of entries plus the single-outstanding-read memory.
    if_entry_t       mq[$];
    if_entry_t       last_e = '0;
    logic            outst = 1'b0;
    logic            dropped = 1'b0;
    logic [XLEN-1:0] pend_pc = '0;
    logic [XLEN-1:0] pc_reg = '0;
    logic            model_ok = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic f, input logic rdy,
                       input logic g, input logic rv_en, input logic [31:0] rd);
        logic      mis, idle, e_req, e_adv, rsp, do_push;
        if_entry_t cur, ne;
        @(negedge clk);
        reset       = rst;
        flush       = f;
        dec_ready   = rdy;
        pc_in       = pc_reg;
        imem_gnt    = g;
        imem_rvalid = outst && rv_en && !rst;
        imem_rdata  = rd;
`ifdef IF_FETCH_ALIGN_CHK_EN
        mis = (pc_reg[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        idle  = !rst && !f && !outst && (mq.size() < DEPTH);
        e_req = idle && !mis;
        e_adv = (e_req && g) || (idle && mis);
        cur   = (mq.size() > 0) ? mq[0] : last_e;
        #1;
        if (model_ok) begin
            check("imem_req", {31'b0, imem_req}, {31'b0, e_req});
            check("pc_adv", {31'b0, pc_adv}, {31'b0, e_adv});
            if (e_req) check("imem_addr", imem_addr, {pc_reg[31:2], 2'b00});
            check("dec_valid", {31'b0, dec_valid}, {31'b0, mq.size() > 0});
            check("dec_pc", dec_pc, cur.pc);
            check("dec_instr", dec_instr, cur.instr);
            check("dec_misalign", {31'b0, dec_misalign}, {31'b0, cur.misalign});
        end
        @(posedge clk);
        if (rst) begin
            mq.delete();
            last_e   = '0;
            outst    = 1'b0;
            dropped  = 1'b0;
            model_ok = 1'b1;
        end else begin
            if (mq.size() > 0) last_e = mq[0];
            rsp     = outst && imem_rvalid;
            do_push = 1'b0;
            ne      = '0;
            if (rsp) begin
                if (!dropped && !f) begin
                    do_push = 1'b1;
                    ne = '{pc: pend_pc, instr: rd, misalign: 1'b0};
                end
                outst   = 1'b0;
                dropped = 1'b0;
            end else if (outst && f) begin
                dropped = 1'b1;
            end
            if (e_req && g) begin
                outst   = 1'b1;
                dropped = 1'b0;
                pend_pc = pc_reg;
            end
            if (idle && mis) begin
                do_push = 1'b1;
                ne = '{pc: pc_reg, instr: INSTR_NOP, misalign: 1'b1};
            end
            if (f) mq.delete();
            else begin
                if (mq.size() > 0 && rdy) void'(mq.pop_front());
                if (do_push) mq.push_back(ne);
            end
            if (e_adv) pc_reg = pc_reg + 32'd4;
        end
    endtask

    initial begin
        // Reset held two cycles with imem stalled, then release at PC 0x40.
        pc_reg = 32'h0000_0040;
        cyc(1, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        // Basic fetch: grant, one wait cycle, response, then present.
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 32'h2008_0005);
        cyc(0, 0, 1, 0, 0, 0);
        // Backpressure fill, then drain to see requests resume.
        for (int i = 0; i < 14; i++) cyc(0, 0, 0, 1, 1, $urandom);
        for (int i = 0; i < 6; i++)  cyc(0, 0, 1, 1, 1, $urandom);
        // Flush while waiting: the late response is dropped.
        cyc(0, 1, 0, 0, 0, 0);
        pc_reg = 32'h0000_0044;
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        cyc(0, 0, 0, 0, 0, 0);
        // Flush coinciding with a response and a pop at count 2.
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h1111_0001);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h1111_0002);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 1, 0, 1, 32'h1111_0003);
        cyc(0, 0, 0, 0, 0, 0);
        // Misaligned PC: marker entry when the check is built in.
        cyc(0, 1, 0, 0, 0, 0);
        pc_reg = 32'h0000_0042;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic r, f;
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 11) == 0);
            cyc(r, f, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                $urandom_range(0, 1) == 1, $urandom);
            if (f || r) begin
                pc_reg = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 7) == 0) pc_reg[1:0] = 2'($urandom_range(1, 3));
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC, issues one instruction-memory read at a time, and buffers returned {pc, instr} pairs in an in-order queue.
- Presents the queue head to decode with a valid/ready handshake.
- Tells the PC register when to advance, and discards wrong-path work on flush.

Parameters:
- DEPTH, 4, queue entries; power of 2, minimum 2.
- XLEN, 32, PC and instruction width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_in  in  XLEN  current PC from the PC register.
- pc_adv  out  1  one-cycle pulse: pc_in was accepted by imem; PC register may load its next value.
- flush  in  1  redirect; drop the queue and any outstanding read.
- imem_req  out  1  read request valid.
- imem_addr  out  XLEN  read address, {pc_in[XLEN-1:2], 2'b00}.
- imem_gnt  in  1  request accepted this cycle when imem_req=1.
- imem_rvalid  in  1  read data valid; exactly one per granted request, at least 1 cycle after grant.
- imem_rdata  in  XLEN  instruction word.
- dec_valid  out  1  queue head valid.
- dec_ready  in  1  decode consumes head when dec_valid=1.
- dec_instr  out  XLEN  head instruction.
- dec_pc  out  XLEN  head PC.
- dec_misalign  out  1  head is a misaligned-fetch marker (see Optional Feature).

Behaviour:
- Reset (clk edge with reset=1):
  - FSM to IDLE; queue count 0.
  - imem_req=0, pc_adv=0, dec_valid=0; dec_instr/dec_pc/dec_misalign=0.
  - Reset mid-read: the pending response is ignored; no rvalid arrives after reset (memory is reset together).
- FSM states:
  - IDLE:
    - imem_req=1 when flush=0 and count<DEPTH; imem_addr/pc driven combinationally.
    - On imem_gnt: capture pc_in into pend_pc, pulse pc_adv in the same cycle, go to WAIT.
  - WAIT:
    - imem_req=0.
    - On imem_rvalid with flush=0: push {pend_pc, imem_rdata, 0}, go to IDLE.
    - On flush without rvalid: go to DROP.
    - On flush with rvalid in the same cycle: discard the data, go to IDLE.
  - DROP:
    - imem_req=0; on imem_rvalid, discard the data and go to IDLE.
    - flush in DROP has no further effect.
- Request in IDLE with flush=1: imem_req=0, so there is no grant and no pc_adv.
- Space reservation: a request is issued only if count<DEPTH in IDLE. At most one read is outstanding, so a push never meets a full queue.
- Queue:
  - Synchronous FIFO with read/write pointers of log2(DEPTH) bits that wrap naturally.
  - count has log2(DEPTH)+1 bits.
  - Pop when dec_valid & dec_ready.
  - Simultaneous push and pop: count unchanged, both take effect.
  - Empty: dec_valid=0 and the dec_* data fields hold their last value.
- Flush:
  - Clears count and pointers on the same edge; any simultaneous pop or push is ignored.
  - dec_valid=0 in the cycle after flush.
- Latency:
  - Grant-to-dec_valid is 1 cycle after the rvalid edge; rvalid is registered into the queue.
  - Best-case throughput is 1 instruction per 2 cycles (request, response).

Optional Feature:
- Macro: IF_FETCH_ALIGN_CHK_EN.
- Defined:
  - In IDLE, if pc_in[1:0]!=0 and count<DEPTH, no imem_req is raised.
  - Instead, push {pc_in, 32'h0000_0000, misalign=1} and pulse pc_adv that cycle. FSM stays in IDLE.
  - dec_misalign reflects the head entry.
- Not defined:
  - pc_in[1:0] is ignored (address forced aligned).
  - dec_misalign is tied 0; no misalign storage bit.

Decomposition:
- Package if_pkg holds:
  - XLEN_DEF=32.
  - Fetch FSM state enum {IDLE, WAIT, DROP}, 2 bits.
  - Queue entry struct {pc, instr, misalign}.
  - INSTR_NOP=32'h0000_0000.
- Sub-module if_fifo: parameterised synchronous FIFO (DEPTH, entry width) with push, pop, clear, count, full, empty. The fetch FSM stays in the top module.

Test Plan:
- Reset with imem stalled: hold reset 2 cycles -> imem_req=0, dec_valid=0, pc_adv=0. Release with pc_in=0x0000_0040 -> imem_req=1, imem_addr=0x0000_0040.
- Basic fetch: gnt immediately, rvalid 2 cycles later with 0x2008_0005, dec_ready=1 -> one pc_adv pulse. Next cycle dec_valid=1, dec_pc=0x40, dec_instr=0x2008_0005.
- Backpressure fill: dec_ready=0, grants and responses always 1 cycle -> exactly DEPTH=4 pushes. imem_req stays 0 afterwards until dec_ready=1 pops one, then requests resume.
- Flush in WAIT: after grant for PC 0x44, assert flush for 1 cycle before rvalid -> response for 0x44 is never presented, queue empty, FSM returns to IDLE on the late rvalid.
- Flush same cycle as rvalid and a pop with queue count 2 -> count 0, data discarded, dec_valid=0 next cycle.
- With IF_FETCH_ALIGN_CHK_EN: pc_in=0x0000_0042 -> no imem_req, pc_adv=1, then dec_valid=1, dec_misalign=1, dec_instr=0x0.
